// File: rtl/mul_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mul_arbiter_pkg
// Shared definitions for the multiplier arbiter slice:
//   - arb_state_e : 2-bit FSM state encoding (IDLE, ISSUE, WAIT, RESP)
//   - DEF_SIZE / DEF_N_REQ / DEF_TIMEOUT : default parameter values
//   - rr_wrap()   : single-step modulo used for round-robin index arithmetic
// ---------------------------------------------------------------------------
package mul_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_e;

    localparam int DEF_SIZE    = 4;
    localparam int DEF_N_REQ   = 4;
    localparam int DEF_TIMEOUT = 64;

    // Callers only ever pass v < 2*n (index + offset, both below n), so a
    // single conditional subtraction is a full modulo here.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? (v - n) : v;
    endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// mul_arbiter_if
// Bundles the requester-side and multiplier-side signals of mul_arbiter.
//   Requester side : req, op_a, op_b (flattened, requester i at [i*Size +: Size])
//                    grant, done, result, err, busy
//   Multiplier side: start_mult, mul_a, mul_b, mult_done, mult_result
// Modports:
//   slave  - used by the arbiter itself
//   master - used by whatever surrounds it (requesters + multiplier)
// ---------------------------------------------------------------------------
interface mul_arbiter_if
    import mul_arbiter_pkg::*;
#(
    parameter int Size  = DEF_SIZE,
    parameter int N_REQ = DEF_N_REQ
);

    logic [N_REQ-1:0]      req;
    logic [N_REQ*Size-1:0] op_a;
    logic [N_REQ*Size-1:0] op_b;
    logic [N_REQ-1:0]      grant;
    logic                  start_mult;
    logic [Size-1:0]       mul_a;
    logic [Size-1:0]       mul_b;
    logic                  mult_done;
    logic [2*Size-1:0]     mult_result;
    logic [N_REQ-1:0]      done;
    logic [2*Size-1:0]     result;
    logic                  err;
    logic                  busy;

    modport slave (
        input  req, op_a, op_b, mult_done, mult_result,
        output grant, start_mult, mul_a, mul_b, done, result, err, busy
    );

    modport master (
        output req, op_a, op_b, mult_done, mult_result,
        input  grant, start_mult, mul_a, mul_b, done, result, err, busy
    );

endinterface

// File: rtl/rr_select.sv
// ---------------------------------------------------------------------------
// rr_select
// Combinational round-robin selector. Searches req starting at index ptr,
// wrapping past N_REQ-1 back to 0, and returns the first set bit.
//   req     : request vector
//   ptr     : index with highest priority this round
//   winner  : one-hot winner, all-zero when req is zero
//   win_idx : binary index of the winner (don't-care when req is zero)
// ---------------------------------------------------------------------------
module rr_select
    import mul_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] winner,
    output logic [IDX_W-1:0] win_idx
);

    // rot_req[k] is the request of the requester k positions after ptr, so a
    // plain fixed-priority search over rot_req implements the rotation.
    logic [N_REQ-1:0] rot_req;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_rot
        assign rot_req[gi] = req[IDX_W'(rr_wrap(int'(ptr) + gi, N_REQ))];
    end

    logic             found;
    logic [IDX_W-1:0] offset;

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && rot_req[k]) begin
                found  = 1'b1;
                offset = IDX_W'(k);
            end
        end
        win_idx = IDX_W'(rr_wrap(int'(ptr) + int'(offset), N_REQ));
        winner  = '0;
        if (found) begin
            winner[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mul_arbiter.sv
// ---------------------------------------------------------------------------
// mul_arbiter
// Shares one external multiplier between N_REQ requesters.
//   clk       : rising-edge clock
//   rst_async : asynchronous active-low reset
//   bus       : mul_arbiter_if.slave
//               in : req, op_a, op_b, mult_done, mult_result
//               out: grant, start_mult, mul_a, mul_b, done, result, err, busy
// Operation: IDLE picks a winner round-robin and latches its operands,
// ISSUE pulses start_mult, WAIT waits for mult_done (bounded by TIMEOUT
// cycles), RESP pulses done to the owner and advances the pointer past it.
// All outputs come straight from registers.
// ---------------------------------------------------------------------------
module mul_arbiter
    import mul_arbiter_pkg::*;
#(
    parameter int Size    = DEF_SIZE,
    parameter int N_REQ   = DEF_N_REQ,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          rst_async,
    mul_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Unflatten operands so the winner's pair is a simple array lookup.
    logic [Size-1:0] op_a_arr [N_REQ];
    logic [Size-1:0] op_b_arr [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ops
        assign op_a_arr[gi] = bus.op_a[gi*Size +: Size];
        assign op_b_arr[gi] = bus.op_b[gi*Size +: Size];
    end

    arb_state_e        state_reg,  state_next;
    logic [IDX_W-1:0]  ptr_reg,    ptr_next;
    logic [IDX_W-1:0]  owner_reg,  owner_next;
    logic [CNT_W-1:0]  cnt_reg,    cnt_next;
    logic [N_REQ-1:0]  grant_reg,  grant_next;
    logic [N_REQ-1:0]  done_reg,   done_next;
    logic              start_reg,  start_next;
    logic [Size-1:0]   mul_a_reg,  mul_a_next;
    logic [Size-1:0]   mul_b_reg,  mul_b_next;
    logic [2*Size-1:0] result_reg, result_next;
    logic              err_reg,    err_next;
    logic              busy_reg,   busy_next;

    logic [N_REQ-1:0]  winner;
    logic [IDX_W-1:0]  win_idx;

    rr_select #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_select (
        .req     (bus.req),
        .ptr     (ptr_reg),
        .winner  (winner),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state_reg  <= IDLE;
            ptr_reg    <= '0;
            owner_reg  <= '0;
            cnt_reg    <= '0;
            grant_reg  <= '0;
            done_reg   <= '0;
            start_reg  <= 1'b0;
            mul_a_reg  <= '0;
            mul_b_reg  <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            ptr_reg    <= ptr_next;
            owner_reg  <= owner_next;
            cnt_reg    <= cnt_next;
            grant_reg  <= grant_next;
            done_reg   <= done_next;
            start_reg  <= start_next;
            mul_a_reg  <= mul_a_next;
            mul_b_reg  <= mul_b_next;
            result_reg <= result_next;
            err_reg    <= err_next;
            busy_reg   <= busy_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        ptr_next    = ptr_reg;
        owner_next  = owner_reg;
        cnt_next    = cnt_reg;
        grant_next  = grant_reg;
        done_next   = '0;
        start_next  = 1'b0;
        mul_a_next  = mul_a_reg;
        mul_b_next  = mul_b_reg;
        result_next = result_reg;
        err_next    = err_reg;

        unique case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    grant_next = winner;
                    owner_next = win_idx;
                    mul_a_next = op_a_arr[win_idx];
                    mul_b_next = op_b_arr[win_idx];
                    // Registered here so the pulse lines up with the ISSUE state.
                    start_next = 1'b1;
                    state_next = ISSUE;
                end
            end

            ISSUE: begin
                cnt_next   = '0;
                state_next = WAIT;
            end

            WAIT: begin
                // A completion on the final allowed cycle still counts as a
                // success rather than a timeout.
                if (bus.mult_done) begin
                    result_next = bus.mult_result;
                    err_next    = 1'b0;
                    done_next   = grant_reg;
                    state_next  = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    result_next = '0;
                    err_next    = 1'b1;
                    done_next   = grant_reg;
                    state_next  = RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            RESP: begin
                grant_next = '0;
                cnt_next   = '0;
                ptr_next   = IDX_W'(rr_wrap(int'(owner_reg) + 1, N_REQ));
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign bus.grant      = grant_reg;
    assign bus.done       = done_reg;
    assign bus.start_mult = start_reg;
    assign bus.mul_a      = mul_a_reg;
    assign bus.mul_b      = mul_b_reg;
    assign bus.result     = result_reg;
    assign bus.err        = err_reg;
    assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_mul_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mul_arbiter
// Directed self-checking bench for mul_arbiter with a small delayed-multiply
// model standing in for the external multiplier.
// ---------------------------------------------------------------------------
module tb_mul_arbiter;

    localparam int SZ = 4;
    localparam int NR = 4;
    localparam int TO = 16;

    logic clk       = 1'b0;
    logic rst_async = 1'b1;

    mul_arbiter_if #(.Size(SZ), .N_REQ(NR)) bus ();

    mul_arbiter #(
        .Size    (SZ),
        .N_REQ   (NR),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst_async (rst_async),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // ---------------- multiplier model ----------------
    logic          model_en;
    int            model_delay;
    int            model_cnt;
    logic          model_done;
    logic [2*SZ-1:0] model_prod;
    logic          stray_done;

    assign bus.mult_done   = model_done | stray_done;
    assign bus.mult_result = stray_done ? 8'hEE : model_prod;

    always @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            model_cnt  <= 0;
            model_done <= 1'b0;
            model_prod <= '0;
        end else begin
            model_done <= 1'b0;
            if (model_cnt != 0) begin
                model_cnt <= model_cnt - 1;
                if (model_cnt == 1) model_done <= 1'b1;
            end else if (bus.start_mult && model_en) begin
                model_prod <= (2*SZ)'(bus.mul_a) * (2*SZ)'(bus.mul_b);
                model_cnt  <= model_delay;
            end
        end
    end

    // ---------------- monitors ----------------
    int start_pulses = 0;
    int done_pulses  = 0;
    int onehot_viol  = 0;

    always @(posedge clk) begin
        if (bus.start_mult === 1'b1) start_pulses <= start_pulses + 1;
        if (bus.done !== '0)         done_pulses  <= done_pulses + 1;
    end

    always @(negedge clk) begin
        if (!$onehot0(bus.grant) || !$onehot0(bus.done)) onehot_viol <= onehot_viol + 1;
    end

    // ---------------- checking helpers ----------------
    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int budget, output int cyc);
        cyc = 0;
        while (bus.grant === '0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (bus.done === '0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    logic [NR-1:0]   exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [2*SZ-1:0] exp_r [5] = '{8'd2, 8'd4, 8'd6, 8'd8, 8'd2};

    initial begin
        int cyc;
        int p0;
        int d0;

        bus.req     = '0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        model_en    = 1'b1;
        model_delay = 4;
        stray_done  = 1'b0;

        // ---------------- reset values ----------------
        #2 rst_async = 1'b0;
        tick(2);
        chk("rst_grant",  bus.grant,      0);
        chk("rst_done",   bus.done,       0);
        chk("rst_busy",   bus.busy,       0);
        chk("rst_start",  bus.start_mult, 0);
        chk("rst_mul_a",  bus.mul_a,      0);
        chk("rst_mul_b",  bus.mul_b,      0);
        chk("rst_result", bus.result,     0);
        chk("rst_err",    bus.err,        0);
        rst_async = 1'b1;
        tick(1);

        // ---------------- single request 3*5 ----------------
        bus.op_a[3:0] = 4'd3;
        bus.op_b[3:0] = 4'd5;
        bus.req       = 4'b0001;
        wait_grant(8, cyc);
        chk("t1_grant_lat", cyc,            1);
        chk("t1_grant",     bus.grant,      4'b0001);
        chk("t1_start",     bus.start_mult, 1);
        chk("t1_mul_a",     bus.mul_a,      3);
        chk("t1_mul_b",     bus.mul_b,      5);
        chk("t1_busy",      bus.busy,       1);
        p0 = start_pulses;
        // Operands change and req drops after grant: neither may matter.
        bus.req       = '0;
        bus.op_a[3:0] = 4'd7;
        bus.op_b[3:0] = 4'd9;
        wait_done(20, cyc);
        chk("t1_done_lat",  cyc,                   6);
        chk("t1_done",      bus.done,              4'b0001);
        chk("t1_result",    bus.result,            8'd15);
        chk("t1_err",       bus.err,               0);
        chk("t1_mul_a_hold", bus.mul_a,            3);
        chk("t1_start_cnt", start_pulses - p0,     1);
        $display("txn single: grant=%b done=%b result=%0d err=%0b", 4'b0001, bus.done, bus.result, bus.err);
        tick(1);
        chk("t1_done_clr",  bus.done,   0);
        chk("t1_idle",      bus.busy,   0);
        chk("t1_grant_clr", bus.grant,  0);
        chk("t1_res_hold",  bus.result, 8'd15);

        // ---------------- contention from ptr=0 ----------------
        rst_async = 1'b0;
        tick(1);
        rst_async = 1'b1;
        tick(1);
        bus.op_a    = {4'd4, 4'd3, 4'd2, 4'd1};
        bus.op_b    = {4'd2, 4'd2, 4'd2, 4'd2};
        model_delay = 2;
        bus.req     = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(8, cyc);
            chk("c_grant", bus.grant, exp_g[i]);
            wait_done(30, cyc);
            chk("c_done",   bus.done,   exp_g[i]);
            chk("c_result", bus.result, exp_r[i]);
            $display("txn contention %0d: grant=%b done=%b result=%0d", i, exp_g[i], bus.done, bus.result);
            if (i == 4) bus.req = '0;
            tick(1);
            chk("c_gap", bus.grant, 0);
        end
        tick(2);
        chk("c_no_more", bus.grant, 0);

        // ---------------- single wins at ptr=1, then wrap from ptr=3 ----------------
        bus.req = 4'b0100;
        wait_grant(8, cyc);
        chk("w_single_grant", bus.grant, 4'b0100);
        bus.req = '0;
        wait_done(30, cyc);
        chk("w_single_done", bus.done,   4'b0100);
        chk("w_single_res",  bus.result, 8'd6);
        $display("txn single@ptr1: done=%b result=%0d", bus.done, bus.result);
        tick(1);
        bus.req = 4'b1001;
        wait_grant(8, cyc);
        chk("w_first_grant", bus.grant, 4'b1000);
        wait_done(30, cyc);
        chk("w_first_done", bus.done,   4'b1000);
        chk("w_first_res",  bus.result, 8'd8);
        $display("txn wrap first: done=%b result=%0d", bus.done, bus.result);
        tick(1);
        wait_grant(8, cyc);
        chk("w_second_grant", bus.grant, 4'b0001);
        bus.req = '0;
        wait_done(30, cyc);
        chk("w_second_done", bus.done,   4'b0001);
        chk("w_second_res",  bus.result, 8'd2);
        $display("txn wrap second: done=%b result=%0d", bus.done, bus.result);
        tick(1);

        // ---------------- timeout ----------------
        model_en = 1'b0;
        bus.req  = 4'b0010;
        wait_grant(8, cyc);
        chk("to_grant", bus.grant, 4'b0010);
        bus.req = '0;
        wait_done(TO + 10, cyc);
        chk("to_lat",    cyc,        TO + 1);
        chk("to_done",   bus.done,   4'b0010);
        chk("to_err",    bus.err,    1);
        chk("to_result", bus.result, 0);
        $display("txn timeout: done=%b err=%0b result=%0d", bus.done, bus.err, bus.result);
        tick(1);
        chk("to_idle", bus.busy, 0);

        // ---------------- reset mid-WAIT ----------------
        bus.req = 4'b0100;
        wait_grant(8, cyc);
        chk("rw_grant", bus.grant, 4'b0100);
        bus.req = '0;
        tick(5);
        chk("rw_busy", bus.busy, 1);
        d0 = done_pulses;
        #2 rst_async = 1'b0;
        #1;
        chk("rw_grant0", bus.grant, 0);
        chk("rw_busy0",  bus.busy,  0);
        chk("rw_mul_a0", bus.mul_a, 0);
        chk("rw_mul_b0", bus.mul_b, 0);
        chk("rw_err0",   bus.err,   0);
        chk("rw_res0",   bus.result, 0);
        tick(2);
        rst_async = 1'b1;
        tick(TO + 4);
        chk("rw_no_done", done_pulses - d0, 0);
        chk("rw_idle",    bus.busy,         0);
        $display("txn reset mid-wait: aborted, done pulses=%0d", done_pulses - d0);

        model_en      = 1'b1;
        model_delay   = 3;
        bus.op_a[3:0] = 4'd6;
        bus.op_b[3:0] = 4'd7;
        bus.req       = 4'b0001;
        wait_grant(8, cyc);
        chk("rw_fresh_grant", bus.grant, 4'b0001);
        bus.req = '0;
        wait_done(30, cyc);
        chk("rw_fresh_done", bus.done,   4'b0001);
        chk("rw_fresh_res",  bus.result, 8'd42);
        chk("rw_fresh_err",  bus.err,    0);
        $display("txn fresh after reset: done=%b result=%0d", bus.done, bus.result);
        tick(1);

        // ---------------- stray mult_done in IDLE ----------------
        stray_done = 1'b1;
        tick(1);
        stray_done = 1'b0;
        chk("st_busy",  bus.busy,  0);
        chk("st_grant", bus.grant, 0);
        chk("st_done",  bus.done,  0);
        tick(1);
        chk("st_done2",  bus.done,   0);
        chk("st_result", bus.result, 8'd42);
        chk("st_busy2",  bus.busy,   0);
        $display("txn stray mult_done: ignored, result=%0d", bus.result);

        // ---------------- req dropped during WAIT ----------------
        bus.op_a[15:12] = 4'd9;
        bus.op_b[15:12] = 4'd9;
        model_delay     = 6;
        bus.req         = 4'b1000;
        wait_grant(8, cyc);
        chk("ld_grant", bus.grant, 4'b1000);
        tick(3);
        chk("ld_busy", bus.busy, 1);
        bus.req = '0;
        wait_done(30, cyc);
        chk("ld_done",   bus.done,   4'b1000);
        chk("ld_result", bus.result, 8'd81);
        $display("txn late drop: done=%b result=%0d", bus.done, bus.result);
        tick(2);
        chk("ld_grant_clr", bus.grant, 0);
        chk("ld_idle",      bus.busy,  0);

        chk("onehot_viol", onehot_viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 Parameter: Size, default 4, operand width in bits.
REQ-002 Parameter: N_REQ, default 4, number of requesters (2..8).
REQ-003 Parameter: TIMEOUT, default 64, maximum cycles spent waiting for mult_done.
REQ-004 Port: clk  input  1  single clock, rising edge.
REQ-005 Port: rst_async  input  1  reset, asynchronous, active-low.
REQ-006 Port: req  input  N_REQ  per-requester multiply request, level.
REQ-007 Port: op_a  input  N_REQ*Size  flattened first operands, requester i at bits [i*Size +: Size].
REQ-008 Port: op_b  input  N_REQ*Size  flattened second operands, same packing.
REQ-009 Port: grant  output  N_REQ  one-hot owner of the multiplier, zero when idle.
REQ-010 Port: start_mult  output  1  one-cycle start pulse to the multiplier buffer.
REQ-011 Port: mul_a, mul_b  output  Size each  registered operands to the multiplier buffer.
REQ-012 Port: mult_done  input  1  multiplier completion pulse.
REQ-013 Port: mult_result  input  2*Size  multiplier product, valid with mult_done.
REQ-014 Port: done  output  N_REQ  one-hot, one-cycle completion pulse to the owner.
REQ-015 Port: result  output  2*Size  registered product, held until the next completion.
REQ-016 Port: err  output  1  high with done when the operation timed out.
REQ-017 Port: busy  output  1  high in every state except IDLE.

Function
REQ-018 FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered.
REQ-019 IDLE: if any req bit is set, select the winner by round-robin from pointer ptr, register grant, latch that requester's op_a/op_b into mul_a/mul_b, and go to ISSUE. Otherwise stay in IDLE.
REQ-020 ISSUE: start_mult=1 for exactly this cycle, then go to WAIT. mult_done is ignored in ISSUE.
REQ-021 WAIT: on mult_done, capture mult_result into result, set err=0, and go to RESP. A cycle counter increments each WAIT cycle; when it reaches TIMEOUT-1 with no mult_done, set result=0, err=1, and go to RESP.
REQ-022 RESP: done[owner]=1 for one cycle, ptr<=owner+1 modulo N_REQ, grant cleared on exit, then go to IDLE.
REQ-023 Round-robin: the search starts at ptr and wraps past N_REQ-1 to 0. When a single requester is active it wins regardless of ptr.
REQ-024 Latency without contention: req rises at edge t, grant is visible after t, start_mult is high in cycle t+1, and done appears 1 cycle after mult_done is sampled.
REQ-025 Operands are sampled only at the grant edge. Later changes to op_a/op_b have no effect on the operation in flight.
REQ-026 If req drops after grant, the operation still completes and done still pulses.
REQ-027 A requester whose req is still high in RESP is eligible again in the next IDLE, but only after the others in round-robin order.
REQ-028 mult_done seen in IDLE, ISSUE or RESP is ignored.
REQ-029 At most one done bit is high in any cycle. grant and done are always one-hot or zero.

Reset
REQ-030 While rst_async=0, asynchronously: state=IDLE, ptr=0, counter=0, grant=0, done=0, start_mult=0, mul_a=0, mul_b=0, result=0, err=0, busy=0.
REQ-031 Reset asserted mid-operation aborts the operation with no done pulse. Requesters must re-request after reset.

Structure
REQ-032 The shared package holds the FSM state encoding (2 bits) and the default Size/N_REQ/TIMEOUT constants.
REQ-033 The round-robin selector is one sub-module, rr_select: combinational, inputs req and ptr, outputs a one-hot winner and its index.
REQ-034 mul_arbiter drives mul_buffer and the multiplier. It does not instantiate them.

Verification
REQ-035 Single request: req=0001, op_a[0]=3, op_b[0]=5, model returns 15 after 4 cycles -> start_mult pulses once, done=0001, result=15, err=0.
REQ-036 Contention: req=1111 held, ptr=0 -> grants occur in order 0001, 0010, 0100, 1000, 0001, with one done per grant.
REQ-037 Wrap: ptr=3, req=1001 -> requester 3 granted first, then requester 0.
REQ-038 Timeout: mult_done never asserted -> done after TIMEOUT WAIT cycles, err=1, result=0, FSM back to IDLE.
REQ-039 Reset mid-WAIT: rst_async pulsed low -> outputs are zero immediately, there is no done, and a fresh request works afterwards.
REQ-040 Stray and late signals: mult_done in IDLE is ignored, and req dropped during WAIT still yields done.
